// File: rtl/freq_sweep_pkg.sv
// freq_sweep_pkg
//   Definitions shared by the frequency sweep tracker:
//   - state_e  : sweep controller states
//   - pass_e   : coarse or fine sweep pass
//   - DEF_*    : default parameter values
//   - sat_add / sat_ovf : unsigned add that saturates at 2^w-1, and its
//                         overflow flag (w <= 32)
package freq_sweep_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETTLE = 3'd1,
        ACCUM  = 3'd2,
        NEXT   = 3'd3,
        DONE   = 3'd4
    } state_e;

    typedef enum logic {
        COARSE = 1'b0,
        FINE   = 1'b1
    } pass_e;

    localparam int DEF_FREQ_W       = 20;
    localparam int DEF_ADC_W        = 12;
    localparam int DEF_STEP_W       = 8;
    localparam int DEF_TMR_W        = 24;
    localparam int DEF_SETTLE_CYC   = 200000;
    localparam int DEF_AVG_LOG2     = 4;
    localparam int DEF_REFINE_SHIFT = 2;

    // a + b, clamped to the largest w-bit value
    function automatic logic [31:0] sat_add(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input int unsigned w);
        logic [32:0] sum;
        logic [32:0] max_val;
        sum     = {1'b0, a} + {1'b0, b};
        max_val = (33'd1 << w) - 33'd1;
        return (sum > max_val) ? max_val[31:0] : sum[31:0];
    endfunction

    // High when a + b does not fit in w bits
    function automatic logic sat_ovf(input logic [31:0] a,
                                     input logic [31:0] b,
                                     input int unsigned w);
        logic [32:0] sum;
        logic [32:0] max_val;
        sum     = {1'b0, a} + {1'b0, b};
        max_val = (33'd1 << w) - 33'd1;
        return (sum > max_val);
    endfunction

endpackage

// File: rtl/freq_sweep_tracker_adc_averager.sv
// adc_averager
//   Sums 2^AVG_LOG2 qualified ADC samples and presents their truncated mean.
//   Ports:
//     clk, nrst        : clock, asynchronous active-low reset
//     clr              : synchronous clear of sum and sample count
//     adc_valid, adc   : qualified sample input
//     avg              : sum >> AVG_LOG2 (valid the cycle after avg_done)
//     avg_done         : combinational pulse in the cycle of the last sample
module adc_averager
    import freq_sweep_pkg::*;
#(
    parameter int ADC_W    = DEF_ADC_W,
    parameter int AVG_LOG2 = DEF_AVG_LOG2
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             clr,
    input  logic             adc_valid,
    input  logic [ADC_W-1:0] adc,
    output logic [ADC_W-1:0] avg,
    output logic             avg_done
);

    localparam int ACC_W = ADC_W + AVG_LOG2;
    // One-bit counter when averaging a single sample; it then never moves
    localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'((1 << AVG_LOG2) - 1);

    logic [ACC_W-1:0] acc_q;
    logic [CNT_W-1:0] cnt_q;

    assign avg_done = adc_valid & ~clr & (cnt_q == LAST_CNT);
    assign avg      = acc_q[AVG_LOG2 +: ADC_W];

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else if (clr) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else if (adc_valid) begin
            acc_q <= acc_q + ACC_W'(adc);
            cnt_q <= avg_done ? '0 : cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/freq_sweep_tracker.sv
// freq_sweep_tracker
//   Steps the generator frequency over a programmable range, settles, averages
//   the ADC at every point and tracks the frequency with the highest average.
//   An optional fine pass re-sweeps +/- 2^REFINE_SHIFT fine steps around the
//   coarse optimum.
//   Ports:
//     clk, nrst            : clock, asynchronous active-low reset
//     swipt_alive          : low = synchronous abort and full clear
//     go                   : rising edge starts, low mid-sweep aborts
//     adc_valid, adc       : ADC sample stream
//     freq_start/freq_step/num_steps/refine_en : sweep config, latched at start
//     new_freq             : frequency command to the generator
//     best_freq, best_adc  : best point found so far
//     busy, done           : sweep running / sweep finished (sticky)
module freq_sweep_tracker
    import freq_sweep_pkg::*;
#(
    parameter int FREQ_W       = DEF_FREQ_W,
    parameter int ADC_W        = DEF_ADC_W,
    parameter int STEP_W       = DEF_STEP_W,
    parameter int TMR_W        = DEF_TMR_W,
    parameter int SETTLE_CYC   = DEF_SETTLE_CYC,
    parameter int AVG_LOG2     = DEF_AVG_LOG2,
    parameter int REFINE_SHIFT = DEF_REFINE_SHIFT
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              swipt_alive,
    input  logic              go,
    input  logic              adc_valid,
    input  logic [ADC_W-1:0]  adc,
    input  logic [FREQ_W-1:0] freq_start,
    input  logic [FREQ_W-1:0] freq_step,
    input  logic [STEP_W-1:0] num_steps,
    input  logic              refine_en,
    output logic [FREQ_W-1:0] new_freq,
    output logic [FREQ_W-1:0] best_freq,
    output logic [ADC_W-1:0]  best_adc,
    output logic              busy,
    output logic              done
);

    // Point counter must hold both the coarse count and the fine count
    localparam int CNT_W = (STEP_W > REFINE_SHIFT + 2) ? STEP_W : REFINE_SHIFT + 2;
    localparam logic [CNT_W-1:0]  FINE_CNT   = CNT_W'(2 * (1 << REFINE_SHIFT) + 1);
    localparam logic [TMR_W-1:0]  TMR_RELOAD = TMR_W'(SETTLE_CYC - 1);

    state_e            state_q;
    pass_e             pass_q;
    logic              go_q;
    logic [FREQ_W-1:0] new_freq_q;
    logic [FREQ_W-1:0] best_freq_q;
    logic [ADC_W-1:0]  best_adc_q;
    logic              busy_q;
    logic              done_q;
    logic [FREQ_W-1:0] freq_start_q;
    logic [FREQ_W-1:0] freq_step_q;
    logic              refine_q;
    logic [FREQ_W-1:0] step_q;       // increment of the current pass
    logic [CNT_W-1:0]  cnt_q;        // points in the current pass
    logic [CNT_W-1:0]  idx_q;        // current point within the pass
    logic [TMR_W-1:0]  timer_q;
    logic              sat_last_q;   // current point was reached by saturation

    logic              start_edge;
    logic              avg_clr;
    logic              avg_valid;
    logic [ADC_W-1:0]  avg_val;
    logic              avg_done;
    logic              best_hit;
    logic [FREQ_W-1:0] best_freq_d;
    logic [ADC_W-1:0]  best_adc_d;
    logic [FREQ_W-1:0] next_freq_d;
    logic              sat_hit;
    logic              last_point;
    logic [FREQ_W-1:0] fs_raw;
    logic [FREQ_W-1:0] fine_step;
    logic [FREQ_W-1:0] fine_off;
    logic [FREQ_W-1:0] fine_start_d;
    logic [CNT_W-1:0]  coarse_cnt;

    assign start_edge = go & ~go_q;

    // Averager is cleared on the last settle cycle and only sees samples in ACCUM
    assign avg_clr   = ~swipt_alive | ((state_q == SETTLE) && (timer_q == '0));
    assign avg_valid = adc_valid & (state_q == ACCUM);

    adc_averager #(
        .ADC_W    (ADC_W),
        .AVG_LOG2 (AVG_LOG2)
    ) u_adc_averager (
        .clk       (clk),
        .nrst      (nrst),
        .clr       (avg_clr),
        .adc_valid (avg_valid),
        .adc       (adc),
        .avg       (avg_val),
        .avg_done  (avg_done)
    );

    // Strict compare: ties keep the earlier point
    assign best_hit    = (avg_val > best_adc_q);
    assign best_freq_d = best_hit ? new_freq_q : best_freq_q;
    assign best_adc_d  = best_hit ? avg_val : best_adc_q;

    assign next_freq_d = FREQ_W'(sat_add(32'(new_freq_q), 32'(step_q), FREQ_W));
    assign sat_hit     = sat_ovf(32'(new_freq_q), 32'(step_q), FREQ_W);
    assign last_point  = sat_last_q | (idx_q == cnt_q - CNT_W'(1));

    // Fine pass starts 2^REFINE_SHIFT fine steps below the (just updated) best
    assign fs_raw       = freq_step_q >> REFINE_SHIFT;
    assign fine_step    = (fs_raw == '0) ? FREQ_W'(1) : fs_raw;
    assign fine_off     = fine_step << REFINE_SHIFT;
    assign fine_start_d = (best_freq_d >= fine_off) ? best_freq_d - fine_off : '0;

    assign coarse_cnt = (num_steps == '0) ? CNT_W'(1) : CNT_W'(num_steps);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q      <= IDLE;
            pass_q       <= COARSE;
            go_q         <= 1'b0;
            new_freq_q   <= '0;
            best_freq_q  <= '0;
            best_adc_q   <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            freq_start_q <= '0;
            freq_step_q  <= '0;
            refine_q     <= 1'b0;
            step_q       <= '0;
            cnt_q        <= '0;
            idx_q        <= '0;
            timer_q      <= '0;
            sat_last_q   <= 1'b0;
        end else if (!swipt_alive) begin
            state_q      <= IDLE;
            pass_q       <= COARSE;
            go_q         <= 1'b0;
            new_freq_q   <= '0;
            best_freq_q  <= '0;
            best_adc_q   <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            freq_start_q <= '0;
            freq_step_q  <= '0;
            refine_q     <= 1'b0;
            step_q       <= '0;
            cnt_q        <= '0;
            idx_q        <= '0;
            timer_q      <= '0;
            sat_last_q   <= 1'b0;
        end else begin
            go_q <= go;
            case (state_q)
                IDLE, DONE: begin
                    if (start_edge) begin
                        freq_start_q <= freq_start;
                        freq_step_q  <= freq_step;
                        refine_q     <= refine_en;
                        step_q       <= freq_step;
                        cnt_q        <= coarse_cnt;
                        idx_q        <= '0;
                        sat_last_q   <= 1'b0;
                        new_freq_q   <= freq_start;
                        best_freq_q  <= freq_start;
                        best_adc_q   <= '0;
                        done_q       <= 1'b0;
                        busy_q       <= 1'b1;
                        pass_q       <= COARSE;
                        timer_q      <= TMR_RELOAD;
                        state_q      <= SETTLE;
                    end
                end
                SETTLE, ACCUM, NEXT: begin
                    if (!go) begin
                        // Abort keeps the best point found so far
                        state_q    <= IDLE;
                        busy_q     <= 1'b0;
                        done_q     <= 1'b0;
                        new_freq_q <= freq_start_q;
                    end else if (state_q == SETTLE) begin
                        if (timer_q == '0) begin
                            state_q <= ACCUM;
                        end else begin
                            timer_q <= timer_q - TMR_W'(1);
                        end
                    end else if (state_q == ACCUM) begin
                        if (avg_done) begin
                            state_q <= NEXT;
                        end
                    end else begin
                        best_freq_q <= best_freq_d;
                        best_adc_q  <= best_adc_d;
                        if (!last_point) begin
                            new_freq_q <= next_freq_d;
                            sat_last_q <= sat_hit;
                            idx_q      <= idx_q + CNT_W'(1);
                            timer_q    <= TMR_RELOAD;
                            state_q    <= SETTLE;
                        end else if ((pass_q == COARSE) && refine_q) begin
                            new_freq_q <= fine_start_d;
                            step_q     <= fine_step;
                            cnt_q      <= FINE_CNT;
                            idx_q      <= '0;
                            sat_last_q <= 1'b0;
                            pass_q     <= FINE;
                            timer_q    <= TMR_RELOAD;
                            state_q    <= SETTLE;
                        end else begin
                            new_freq_q <= best_freq_d;
                            busy_q     <= 1'b0;
                            done_q     <= 1'b1;
                            state_q    <= DONE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign new_freq  = new_freq_q;
    assign best_freq = best_freq_q;
    assign best_adc  = best_adc_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
